// File: rtl/irq_arbiter.sv
// irq_arbiter: latches rising-edge interrupt requests from the timer and the
// UART, masks them with a software enable register, presents the
// highest-priority request to the CPU control unit as a 2-bit code, and
// follows acceptance and return through the kernel-mode flag monin.
// IE, IP and ISR registers are memory-mapped on the peripheral bus.
module irq_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  src,
    input  logic        monin,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [1:0]  IRQ
);

    localparam logic [31:0] IE_ADDR  = 32'h4000_0030;
    localparam logic [31:0] IP_ADDR  = 32'h4000_0034;
    localparam logic [31:0] ISR_ADDR = 32'h4000_0038;

    logic [2:0] src_d;
    logic [2:0] ie;
    logic [2:0] ip;
    logic [1:0] isr;
    logic       monin_d;
    logic [1:0] irq_d;

    logic [2:0] req;
    logic [2:0] src_rise;
    logic [2:0] w1c_mask;
    logic [2:0] accept_mask;
    logic       accept;
    logic       ret;
    logic       ie_write;
    logic       ip_write;
    logic       unused_write_bits;

    assign req      = ip & ie;
    assign src_rise = src & ~src_d;
    assign accept   = monin & ~monin_d & (irq_d != 2'b00);
    assign ret      = ~monin & monin_d;
    assign ie_write = MemWrite && (Addr == IE_ADDR);
    assign ip_write = MemWrite && (Addr == IP_ADDR);
    assign w1c_mask = ip_write ? WriteData[2:0] : 3'b000;

    assign unused_write_bits = ^WriteData[31:3];

    // Decode the code that was presented before kernel entry into the pending bit it clears
    always_comb begin
        accept_mask = 3'b000;
        if (accept) begin
            case (irq_d)
                2'b01:   accept_mask = 3'b001;
                2'b10:   accept_mask = 3'b010;
                2'b11:   accept_mask = 3'b100;
                default: accept_mask = 3'b000;
            endcase
        end
    end

    // Present the highest pending enabled request, but only outside kernel mode and with nothing in service
    always_comb begin
        IRQ = 2'b00;
        if (!monin && (isr == 2'b00)) begin
            if (req[2]) begin
                IRQ = 2'b11;
            end else if (req[1]) begin
                IRQ = 2'b10;
            end else if (req[0]) begin
                IRQ = 2'b01;
            end
        end
    end

    // Bus read mux; unaddressed or idle reads return zero
    always_comb begin
        ReadData = 32'h0;
        if (MemRead) begin
            case (Addr)
                IE_ADDR:  ReadData = {29'h0, ie};
                IP_ADDR:  ReadData = {29'h0, ip};
                ISR_ADDR: ReadData = {30'h0, isr};
                default:  ReadData = 32'h0;
            endcase
        end
    end

    // Register edge history, pending bits, mask and in-service tracking; a new source edge beats any clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_d   <= 3'b000;
            ie      <= 3'b000;
            ip      <= 3'b000;
            isr     <= 2'b00;
            monin_d <= 1'b0;
            irq_d   <= 2'b00;
        end else begin
            src_d   <= src;
            monin_d <= monin;
            irq_d   <= IRQ;
            ip      <= src_rise | (ip & ~(w1c_mask | accept_mask));
            if (ie_write) begin
                ie <= WriteData[2:0];
            end
            if (accept) begin
                isr <= irq_d;
            end else if (ret) begin
                isr <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: expected values are queued when a check
// is set up and popped when the DUT output is sampled.
module tb_irq_arbiter;

    localparam logic [31:0] IE_ADDR  = 32'h4000_0030;
    localparam logic [31:0] IP_ADDR  = 32'h4000_0034;
    localparam logic [31:0] ISR_ADDR = 32'h4000_0038;

    logic        clk;
    logic        reset;
    logic [2:0]  src;
    logic        monin;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [1:0]  IRQ;

    int checkCount;
    int errorCount;
    logic [31:0] expQ[$];

    irq_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .monin     (monin),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .IRQ       (IRQ)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, leaving inputs free to change 1 ns after the edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        Addr      = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        tick(1);
        MemWrite  = 1'b0;
        WriteData = 32'h0;
    endtask

    task automatic expectReg(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        logic [31:0] observed;
        logic [31:0] want;
        expQ.push_back(expected);
        Addr    = addr;
        MemRead = 1'b1;
        #1;
        observed = ReadData;
        MemRead  = 1'b0;
        #0;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'h1, 32'h0);
        end else begin
            want = expQ.pop_front();
            checkOutput(tag, observed, want);
        end
    endtask

    task automatic expectIrq(input string tag, input logic [1:0] expected);
        logic [31:0] want;
        expQ.push_back({30'h0, expected});
        #0;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'h1, 32'h0);
        end else begin
            want = expQ.pop_front();
            checkOutput(tag, {30'h0, IRQ}, want);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] pulse);
        src = pulse;
        tick(1);
        src = 3'b000;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b0;
        src        = 3'b000;
        monin      = 1'b0;
        Addr       = 32'h0;
        WriteData  = 32'h0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;

        // Reset state
        tick(2);
        expectIrq("rst_irq", 2'b00);
        expectReg("rst_ie", IE_ADDR, 32'h0);
        expectReg("rst_ip", IP_ADDR, 32'h0);
        expectReg("rst_isr", ISR_ADDR, 32'h0);
        expectReg("unmapped", 32'h4000_003C, 32'h0);
        reset = 1'b1;
        tick(1);

        // Single timer request, accept and return
        busWrite(IE_ADDR, 32'h7);
        expectReg("ie_rw", IE_ADDR, 32'h7);
        applyStimulus(3'b001);
        expectIrq("single_irq", 2'b01);
        expectReg("single_ip", IP_ADDR, 32'h1);
        tick(1);
        monin = 1'b1;
        expectIrq("single_monin_irq", 2'b00);
        tick(1);
        expectReg("single_isr", ISR_ADDR, 32'h1);
        expectReg("single_ip_clr", IP_ADDR, 32'h0);
        busWrite(ISR_ADDR, 32'h3);
        expectReg("isr_ro", ISR_ADDR, 32'h1);
        tick(2);
        monin = 1'b0;
        expectIrq("single_isr_hold", 2'b00);
        tick(1);
        expectReg("single_ret_isr", ISR_ADDR, 32'h0);
        expectIrq("single_ret_irq", 2'b00);

        // Priority: all three at once, serviced TX, RX, timer
        applyStimulus(3'b111);
        expectIrq("prio_tx", 2'b11);
        tick(1);
        monin = 1'b1;
        tick(1);
        expectReg("prio_isr_tx", ISR_ADDR, 32'h3);
        expectReg("prio_ip_after_tx", IP_ADDR, 32'h3);
        expectIrq("prio_nonest", 2'b00);
        monin = 1'b0;
        tick(1);
        expectIrq("prio_rx", 2'b10);
        tick(1);
        monin = 1'b1;
        tick(1);
        expectReg("prio_isr_rx", ISR_ADDR, 32'h2);
        monin = 1'b0;
        tick(1);
        expectIrq("prio_timer", 2'b01);
        tick(1);
        monin = 1'b1;
        tick(1);
        expectReg("prio_isr_timer", ISR_ADDR, 32'h1);
        monin = 1'b0;
        tick(1);
        expectReg("prio_ip_end", IP_ADDR, 32'h0);
        expectIrq("prio_irq_end", 2'b00);

        // Mask: pending latched regardless of enable
        busWrite(IE_ADDR, 32'h1);
        applyStimulus(3'b110);
        expectIrq("mask_irq", 2'b00);
        expectReg("mask_ip", IP_ADDR, 32'h6);
        busWrite(IE_ADDR, 32'h7);
        expectIrq("mask_unmask", 2'b11);
        busWrite(IP_ADDR, 32'h6);
        expectReg("mask_w1c", IP_ADDR, 32'h0);

        // W1C colliding with a new source edge: the set wins
        applyStimulus(3'b001);
        tick(1);
        expectReg("w1c_pre", IP_ADDR, 32'h1);
        src = 3'b001;
        busWrite(IP_ADDR, 32'h1);
        src = 3'b000;
        expectReg("w1c_vs_edge", IP_ADDR, 32'h1);
        busWrite(IP_ADDR, 32'h1);
        expectReg("w1c_clear", IP_ADDR, 32'h0);

        // A held-high source triggers once only
        src = 3'b001;
        tick(1);
        busWrite(IP_ADDR, 32'h1);
        tick(2);
        expectReg("held_once", IP_ADDR, 32'h0);
        src = 3'b000;
        tick(1);

        // Exception entry with nothing presented leaves ISR and IP alone
        busWrite(IE_ADDR, 32'h1);
        applyStimulus(3'b010);
        expectIrq("exc_irq", 2'b00);
        tick(1);
        monin = 1'b1;
        tick(2);
        expectReg("exc_isr", ISR_ADDR, 32'h0);
        expectReg("exc_ip", IP_ADDR, 32'h2);
        monin = 1'b0;
        tick(1);
        busWrite(IP_ADDR, 32'h7);

        // Reset mid-service
        busWrite(IE_ADDR, 32'h7);
        applyStimulus(3'b010);
        tick(1);
        monin = 1'b1;
        tick(1);
        applyStimulus(3'b101);
        expectReg("rstsvc_isr_pre", ISR_ADDR, 32'h2);
        expectReg("rstsvc_ip_pre", IP_ADDR, 32'h5);
        monin = 1'b0;
        src   = 3'b111;
        #1;
        reset = 1'b0;
        #1;
        expectIrq("rstsvc_irq", 2'b00);
        expectReg("rstsvc_isr", ISR_ADDR, 32'h0);
        expectReg("rstsvc_ip", IP_ADDR, 32'h0);
        expectReg("rstsvc_ie", IE_ADDR, 32'h0);
        tick(1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            expectIrq("rstsvc_held_src", 2'b00);
        end
        src = 3'b000;
        tick(1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
